// File: rtl/gsim_pkg.sv
// Shared constants, FSM state type and output rounding helper for the banded
// matrix-vector multiplier that re-derives b from a Gauss-Seidel solution.
package gsim_pkg;

    localparam int XW   = 32;
    localparam int YW   = 38;
    localparam int FRAC = 16;

    localparam int C0 = 20;
    localparam int C1 = -13;
    localparam int C2 = 6;
    localparam int C3 = -1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    // Round half toward +inf, drop the fraction, then clamp to int16.
    function automatic logic signed [15:0] round_sat16(input logic signed [YW-1:0] y);
        logic signed [YW:0]      biased;
        logic signed [YW-FRAC:0] q;
        biased = $signed({y[YW-1], y}) + $signed((YW+1)'(1 << (FRAC-1)));
        q      = biased[YW:FRAC];
        if (q > $signed((YW-FRAC+1)'(32767)))
            round_sat16 = 16'sh7FFF;
        else if (q < $signed((YW-FRAC+1)'(-32768)))
            round_sat16 = 16'sh8000;
        else
            round_sat16 = q[15:0];
    endfunction

endpackage

// File: rtl/gsim_band_mac.sv
// Combinational 7-tap symmetric dot product for the 20/-13/6/-1 band,
// built from pre-added symmetric pairs and shift-add constant multiplies.
module gsim_band_mac #(
    parameter int XW = gsim_pkg::XW,
    parameter int YW = gsim_pkg::YW
) (
    input  logic [7*XW-1:0] win,
    output logic [YW-1:0]   y
);

    logic signed [YW-1:0] tap [7];
    logic signed [YW-1:0] p0;
    logic signed [YW-1:0] p1;
    logic signed [YW-1:0] p2;
    logic signed [YW-1:0] t3;

    for (genvar gi = 0; gi < 7; gi++) begin : g_tap
        assign tap[gi] = {{(YW-XW){win[gi*XW+XW-1]}}, win[gi*XW +: XW]};
    end

    assign p0 = tap[0] + tap[6];
    assign p1 = tap[1] + tap[5];
    assign p2 = tap[2] + tap[4];
    assign t3 = tap[3];

    // 20 = 16+4, 13 = 8+4+1, 6 = 4+2; guard bits make every term exact.
    assign y = (t3 <<< 4) + (t3 <<< 2)
             - ((p2 <<< 3) + (p2 <<< 2) + p2)
             + (p1 <<< 2) + (p1 <<< 1)
             - p0;

endmodule

// File: rtl/gsim_matvec.sv
// Streaming y = M*x for the 7-band Gauss-Seidel matrix: owns the sample window,
// the IDLE/RUN/FLUSH sequencer and the registered y/b outputs.
module gsim_matvec
    import gsim_pkg::*;
#(
    parameter int N  = 16,
    parameter int XW = gsim_pkg::XW,
    parameter int YW = gsim_pkg::YW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    input  logic [XW-1:0] x_in,
    output logic          out_valid,
    output logic [YW-1:0] y_out,
    output logic [15:0]   b_out,
    output logic          frame_done,
    output logic          overrun
);

    localparam int CW = $clog2(N + 1);

    state_t               state_reg;
    logic [CW-1:0]        count_reg;
    logic [1:0]           flush_cnt_reg;
    logic signed [XW-1:0] window_reg [7];
    logic                 win_valid_reg;
    logic                 last_reg;
    logic                 out_valid_reg;
    logic                 frame_done_reg;
    logic                 overrun_reg;
    logic signed [YW-1:0] y_out_reg;
    logic signed [15:0]   b_out_reg;
    logic [7*XW-1:0]      win_flat;
    logic [YW-1:0]        mac_y;

    for (genvar gi = 0; gi < 7; gi++) begin : g_flat
        assign win_flat[gi*XW +: XW] = window_reg[gi];
    end

    gsim_band_mac #(
        .XW (XW),
        .YW (YW)
    ) u_mac (
        .win (win_flat),
        .y   (mac_y)
    );

    // win_valid_reg marks a window whose centre is a real row; the output
    // registers sample the MAC one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            flush_cnt_reg  <= '0;
            for (int i = 0; i < 7; i++) window_reg[i] <= '0;
            win_valid_reg  <= 1'b0;
            last_reg       <= 1'b0;
            out_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            y_out_reg      <= '0;
            b_out_reg      <= '0;
        end else begin
            out_valid_reg  <= win_valid_reg;
            frame_done_reg <= last_reg;
            if (win_valid_reg) begin
                y_out_reg <= $signed(mac_y);
                b_out_reg <= round_sat16($signed(mac_y));
            end
            win_valid_reg <= 1'b0;
            last_reg      <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (in_en) begin
                        for (int i = 0; i < 6; i++) window_reg[i] <= window_reg[i+1];
                        window_reg[6] <= $signed(x_in);
                        count_reg     <= CW'(1);
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    if (in_en) begin
                        for (int i = 0; i < 6; i++) window_reg[i] <= window_reg[i+1];
                        window_reg[6] <= $signed(x_in);
                        count_reg     <= count_reg + CW'(1);
                        win_valid_reg <= (count_reg >= CW'(3));
                        if (count_reg == CW'(N - 1)) begin
                            flush_cnt_reg <= '0;
                            state_reg     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (in_en) overrun_reg <= 1'b1;
                    if (flush_cnt_reg != 2'd3) begin
                        for (int i = 0; i < 6; i++) window_reg[i] <= window_reg[i+1];
                        window_reg[6] <= '0;
                        win_valid_reg <= 1'b1;
                        last_reg      <= (flush_cnt_reg == 2'd2);
                        flush_cnt_reg <= flush_cnt_reg + 2'd1;
                    end else begin
                        // Last output is loading from this window now; safe to clear.
                        for (int i = 0; i < 7; i++) window_reg[i] <= '0;
                        count_reg     <= '0;
                        flush_cnt_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_reg;
    assign y_out      = y_out_reg;
    assign b_out      = b_out_reg;
    assign frame_done = frame_done_reg;
    assign overrun    = overrun_reg;

endmodule
